matrix_fetch: RTL and testbench

- Avalon-MM pipelined read master that loads a row-major N×N single-precision matrix from SDRAM into the determinant engine's on-chip matrix RAM.
- Sits directly upstream of the determinant calculation stage: started with a base address and dimension, signals `done` once the final element is written to RAM.
- Decouples SDRAM latency and back-pressure from the calculation FSM, bounding in-flight reads with a credit counter.

---
 rtl/fp_det_pkg.sv | 15 +
 rtl/matrix_fetch_if.sv | 14 +
 rtl/matrix_fetch.sv | 143 ++++++++++++++
 tb/tb_matrix_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_det_pkg.sv
// Types and constants shared by the matrix fetch and determinant calculation stages.
package fp_det_pkg;
    localparam int ADDR_WIDTH     = 24;
    localparam int RAM_ADDR_WIDTH = 10;
    localparam int MAX_DIMENSION  = 32;

    typedef logic [5:0]  dim_t;
    typedef logic [10:0] count_t;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_t;

    function automatic count_t elem_count(input dim_t n);
        return count_t'(n) * count_t'(n);
    endfunction
endpackage

// File: rtl/matrix_fetch_if.sv
// Avalon-MM pipelined read bus between the matrix fetch master and SDRAM.
interface matrix_fetch_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (output address, read, input readdata, readdatavalid, waitrequest);
    modport slave  (input address, read, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/matrix_fetch.sv
// Loads a row-major NxN matrix from SDRAM into matrix RAM; read issued the cycle after start,
// RAM write one cycle after each response; waitrequest stalls issue, credits bound in-flight reads.
module matrix_fetch #(
    parameter int ADDR_WIDTH      = fp_det_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = 32,
    parameter int RAM_ADDR_WIDTH  = fp_det_pkg::RAM_ADDR_WIDTH,
    parameter int MAX_DIMENSION   = fp_det_pkg::MAX_DIMENSION,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  fp_det_pkg::dim_t          dimension,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    matrix_fetch_if.master            bus,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DATA_WIDTH-1:0]     ram_wrdata,
    output logic                      ram_wren
);
    import fp_det_pkg::*;

    localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  read_q;
    count_t                total;
    count_t                issued;
    count_t                received;
    logic [CRED_W-1:0]     credits;

    logic                  accept;
    logic                  rsp;
    logic                  stalled;
    logic                  more;
    logic                  bad_start;
    logic [CRED_W-1:0]     credits_nxt;
    count_t                issued_nxt;

    assign bus.address = addr_q;
    assign bus.read    = read_q;

    assign accept  = read_q && !bus.waitrequest;
    assign stalled = read_q && bus.waitrequest;
    // Responses outside an active or flushing load are strays and are dropped entirely.
    assign rsp     = bus.readdatavalid && (state == ISSUE || state == DRAIN || state == FLUSH);

    always_comb begin
        credits_nxt = credits;
        if (accept && !rsp)
            credits_nxt = credits + CRED_W'(1);
        else if (!accept && rsp)
            credits_nxt = credits - CRED_W'(1);
    end

    assign issued_nxt = issued + count_t'(accept);
    assign more       = (issued_nxt < total) && (credits_nxt < CRED_W'(MAX_OUTSTANDING));
    assign bad_start  = (dimension < dim_t'(2)) || (dimension > dim_t'(MAX_DIMENSION)) ||
                        (base_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            read_q        <= 1'b0;
            total         <= '0;
            issued        <= '0;
            received      <= '0;
            credits       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_wrdata    <= '0;
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            ram_wren <= 1'b0;
            credits  <= credits_nxt;
            issued   <= issued_nxt;
            if (accept)
                addr_q <= addr_q + ADDR_WIDTH'(4);
            if (rsp && state != FLUSH) begin
                ram_wren      <= 1'b1;
                ram_wraddress <= received[RAM_ADDR_WIDTH-1:0];
                ram_wrdata    <= bus.readdata;
                received      <= received + count_t'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_start) begin
                            error <= 1'b1;
                        end else begin
                            addr_q   <= base_addr;
                            total    <= elem_count(dimension);
                            issued   <= '0;
                            received <= '0;
                            read_q   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        // A request caught in waitrequest must still complete on the bus.
                        read_q <= stalled;
                        state  <= FLUSH;
                    end else begin
                        read_q <= more || stalled;
                        if (issued_nxt == total)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= FLUSH;
                    end else if (received == total) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                FLUSH: begin
                    read_q <= stalled;
                    if (credits == '0 && !read_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_fetch.sv
// Bench for matrix_fetch: Avalon slave model with latency/stall control and a RAM-write scoreboard.
module tb_matrix_fetch;
    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] base_addr;
    logic [5:0]  dimension;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  ram_wraddress;
    logic [31:0] ram_wrdata;
    logic        ram_wren;

    matrix_fetch_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) bus ();

    matrix_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .dimension     (dimension),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .bus           (bus),
        .ram_wraddress (ram_wraddress),
        .ram_wrdata    (ram_wrdata),
        .ram_wren      (ram_wren)
    );

    typedef struct { int due; logic [31:0] dat; } rsp_t;
    typedef struct { int idx; logic [31:0] dat; } wr_t;

    rsp_t pend[$];
    wr_t  sb[$];

    int checks = 0;
    int errors = 0;

    // Slave configuration, written only by the main sequence.
    int cfg_base  = 0;
    int cfg_lat   = 3;
    bit cfg_stall = 0;

    // Per-load statistics, written only by the slave model; cleared when it sees start.
    int cyc = 0;
    int ld_acc = 0, ld_resp = 0, ld_wr = 0, ld_done = 0, ld_reads = 0;
    int ld_late = 0, ld_dropped = 0, ld_stall = 0, max_out = 0;
    int last_wr_cyc = 0, last_rsp_cyc = 0;
    bit aborted = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat_of(input int k);
        case (k)
            0:       return 32'h3F80_0000;
            1:       return 32'h4000_0000;
            2:       return 32'h4040_0000;
            3:       return 32'h4080_0000;
            default: return 32'hA500_0000 | 32'(k);
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Avalon slave + RAM monitor, all on the falling edge.
    initial begin : slave
        rsp_t r;
        wr_t  w;
        int   stall_left;
        int   stall_idx;
        bit   prev_busy;
        stall_left = 0;
        stall_idx  = -1;
        prev_busy  = 0;
        bus.readdata      = '0;
        bus.readdatavalid = 1'b0;
        bus.waitrequest   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend.delete();
                sb.delete();
                bus.readdatavalid = 1'b0;
                bus.waitrequest   = 1'b0;
                stall_left        = 0;
                prev_busy         = 0;
                continue;
            end
            if (start) begin
                ld_acc = 0; ld_resp = 0; ld_wr = 0; ld_done = 0; ld_reads = 0;
                ld_late = 0; ld_dropped = 0; ld_stall = 0; max_out = 0;
                aborted = 0; stall_idx = -1; stall_left = 0;
            end

            if (ram_wren) begin
                if (sb.size() == 0) begin
                    check_eq("wr_unexpected", 32'(ram_wraddress), 32'hFFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    check_eq("wr_addr", 32'(ram_wraddress), 32'(w.idx));
                    check_eq("wr_data", ram_wrdata, w.dat);
                end
                ld_wr++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                ld_done++;
                check_eq("done_gap", 32'(cyc - last_wr_cyc), 32'd1);
                check_eq("done_busy", 32'(busy), 32'd0);
            end
            if (prev_busy && !busy && aborted)
                check_eq("abort_busy_lat", 32'(cyc - last_rsp_cyc), 32'd2);
            prev_busy = busy;

            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                bus.readdatavalid = 1'b1;
                bus.readdata      = r.dat;
                last_rsp_cyc      = cyc;
                if (!aborted) sb.push_back('{ld_resp, r.dat});
                else          ld_dropped++;
                ld_resp++;
            end else begin
                bus.readdatavalid = 1'b0;
                bus.readdata      = $urandom;
            end

            bus.waitrequest = 1'b0;
            if (bus.read) begin
                ld_reads++;
                if (aborted) ld_late++;
                check_eq("rd_addr", 32'(bus.address), 32'(cfg_base + 4 * ld_acc));
                if (cfg_stall && (ld_acc % 3 == 2) && stall_idx != ld_acc) begin
                    stall_left = 2;
                    stall_idx  = ld_acc;
                end
                if (stall_left > 0) begin
                    bus.waitrequest = 1'b1;
                    stall_left--;
                    ld_stall++;
                end else begin
                    pend.push_back('{cyc + cfg_lat, dat_of(ld_acc)});
                    ld_acc++;
                    if (ld_acc - ld_resp > max_out) max_out = ld_acc - ld_resp;
                end
            end
            if (abort) aborted = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic outputs_zero(input string tag);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_done"},  32'(done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
        check_eq({tag, "_read"},  32'(bus.read), 32'd0);
        check_eq({tag, "_addr"},  32'(bus.address), 32'd0);
        check_eq({tag, "_wren"},  32'(ram_wren), 32'd0);
        check_eq({tag, "_wradr"}, 32'(ram_wraddress), 32'd0);
        check_eq({tag, "_wrdat"}, ram_wrdata, 32'd0);
    endtask

    task automatic kick(input int n, input int base, input int lat, input bit stall);
        cfg_base  = base;
        cfg_lat   = lat;
        cfg_stall = stall;
        dimension = 6'(n);
        base_addr = 24'(base);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_load(input int n, input int base, input int lat, input bit stall);
        int budget;
        kick(n, base, lat, stall);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_read", 32'(bus.read), 32'd1);
        check_eq("t1_addr", 32'(bus.address), 32'(base));
        budget = n * n * (lat + 4) + 100;
        for (int i = 0; i < budget && ld_done == 0; i++) tick();
        repeat (3) tick();
        check_eq("ld_done", 32'(ld_done), 32'd1);
        check_eq("ld_acc", 32'(ld_acc), 32'(n * n));
        check_eq("ld_wr", 32'(ld_wr), 32'(n * n));
        check_eq("ld_sb_left", 32'(sb.size()), 32'd0);
        check_eq("ld_addr_end", 32'(bus.address), 32'(base + 4 * n * n));
        check_eq("ld_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic bad_start(input int n, input int base);
        kick(n, base, 3, 0);
        check_eq("err_pulse", 32'(error), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        check_eq("err_read", 32'(bus.read), 32'd0);
        tick();
        check_eq("err_clear", 32'(error), 32'd0);
        repeat (4) tick();
        check_eq("err_busy_later", 32'(busy), 32'd0);
        check_eq("err_no_reads", 32'(ld_reads), 32'd0);
    endtask

    initial begin : main
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        dimension = '0;
        repeat (3) tick();
        outputs_zero("rst");
        reset = 1'b0;
        tick();

        run_load(2, 'h100, 3, 0);
        run_load(3, 'h200, 2, 1);
        check_eq("n3_stall_cycles", 32'(ld_stall), 32'd6);
        run_load(4, 'h4000, 20, 0);
        check_eq("n4_max_credits", 32'(max_out), 32'd8);
        run_load(32, 'h10000, 3, 0);

        bad_start(1, 'h100);
        bad_start(33, 'h100);
        bad_start(4, 'h102);

        // Abort after five acceptances; late responses must be dropped.
        kick(4, 'h800, 3, 0);
        for (int i = 0; i < 50 && ld_acc < 5; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        repeat (5) tick();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_no_done", 32'(ld_done), 32'd0);
        check_eq("abort_late_reads", 32'(ld_late), 32'd0);
        check_eq("abort_sb_left", 32'(sb.size()), 32'd0);
        check_eq("abort_pend_left", 32'(pend.size()), 32'd0);
        check_eq("abort_dropped_some", 32'(ld_dropped > 0), 32'd1);
        check_eq("abort_wrote_some", 32'(ld_wr > 0), 32'd1);
        run_load(2, 'h300, 3, 0);

        // Reset in the middle of a long-latency load.
        kick(4, 'h900, 20, 0);
        for (int i = 0; i < 50 && ld_acc < 3; i++) tick();
        reset = 1'b1;
        tick();
        outputs_zero("midrst");
        reset = 1'b0;
        tick();
        run_load(2, 'h500, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
